alu_control_sequencer: RTL and testbench

Parametrised control-step sequencer for the bus-based CPU datapath. It drives the per-step strobes that benches currently hand-sequence (T0–T5) for fetch and register-register ALU instructions, and adds memory wait-state handling, two-step HI/LO writeback for MUL/DIV, illegal-opcode detection and a retired-instruction counter. It sits beside the `CPU` datapath and connects directly to its control inputs.

---
 rtl/cpu_ctrl_pkg.sv | 37 +++
 rtl/reg_select_decoder.sv | 19 +
 rtl/alu_control_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the CPU control-step sequencer.
// Holds the opcode values, the FSM state and opcode-class enums, the IR field
// bit positions and a helper that sorts an opcode into its class.
package cpu_ctrl_pkg;

  localparam int OPC_BITS = 5;

  localparam logic [OPC_BITS-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_BITS-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_BITS-1:0] OP_AND = 5'b01010;
  localparam logic [OPC_BITS-1:0] OP_OR  = 5'b01011;
  localparam logic [OPC_BITS-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_BITS-1:0] OP_DIV = 5'b10000;

  // IR field positions (low bit of each field)
  localparam int OPC_LO = 27;
  localparam int RA_LO  = 23;
  localparam int RB_LO  = 19;
  localparam int RC_LO  = 15;

  typedef enum logic [2:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
  } state_e;

  typedef enum logic [1:0] {
    C_RR, C_MD, C_ILL
  } class_e;

  function automatic class_e op_class(input logic [OPC_BITS-1:0] opc);
    case (opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return C_RR;
      OP_MUL, OP_DIV:                return C_MD;
      default:                       return C_ILL;
    endcase
  endfunction

endpackage

// File: rtl/reg_select_decoder.sv
// One-hot register select decoder.
// Ports: idx (REG_W) register index, en enable, onehot (NREG) decoded select;
// onehot is all-zero when en is low.
module reg_select_decoder #(
  parameter int NREG  = 16,
  parameter int REG_W = 4
) (
  input  logic [REG_W-1:0] idx,
  input  logic             en,
  output logic [NREG-1:0]  onehot
);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NREG; i++)
      onehot[i] = en && (idx == REG_W'(i));
  end

endmodule

// File: rtl/alu_control_sequencer.sv
// Control-step sequencer for the bus-based CPU datapath.
// Steps fetch (T0-T2), decode (T3) and execute (T4-T6) for register-register
// ALU ops and MUL/DIV, waits in T1 for memory, flags illegal opcodes and
// counts retired instructions.
// Ports:
//   clock, clear        clock (rising edge) and async active-high reset
//   run                 permits a new fetch (sampled in IDLE and at completion)
//   mem_ready           memory read data valid
//   ir                  IR contents from the datapath
//   PCout..LOin         datapath strobes
//   r_out, r_in         one-hot register bus enable / register load
//   alu_op              opcode to the ALU, nonzero only while Zin is high
//   illegal             one-cycle pulse in T3 for undecodable opcodes
//   step                current T-step index, 0 in IDLE
//   instr_count         retired-instruction counter, wraps
module alu_control_sequencer
  import cpu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NREG   = 16,
  parameter int REG_W  = 4,
  parameter int OPC_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              run,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] ir,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              memRead,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              Zin,
  output logic              Zlowout,
  output logic              Zhighout,
  output logic              HIin,
  output logic              LOin,
  output logic [NREG-1:0]   r_out,
  output logic [NREG-1:0]   r_in,
  output logic [OPC_W-1:0]  alu_op,
  output logic              illegal,
  output logic [2:0]        step,
  output logic [CNT_W-1:0]  instr_count
);

  state_e           state, state_nxt;
  logic [OPC_W-1:0] opc_q;
  logic [REG_W-1:0] ra_q, rb_q, rc_q;
  class_e           cls;
  logic             done;

  logic             ro_en, ri_en;
  logic [REG_W-1:0] ro_idx, ri_idx;

  // Only the opcode and register fields are decoded here.
  logic unused_ir;
  assign unused_ir = ^ir[RC_LO-1:0];

  assign cls = op_class(opc_q);

  // Instruction retires at the last execute step of its class.
  assign done = (state == S_T6) || ((state == S_T5) && (cls == C_RR));

  always_ff @(posedge clock or posedge clear) begin
    if (clear) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // IR fields are captured on the T2->T3 edge so later IR changes are ignored.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      opc_q <= '0;
      ra_q  <= '0;
      rb_q  <= '0;
      rc_q  <= '0;
    end else if (state == S_T2) begin
      opc_q <= ir[OPC_LO +: OPC_W];
      ra_q  <= ir[RA_LO  +: REG_W];
      rb_q  <= ir[RB_LO  +: REG_W];
      rc_q  <= ir[RC_LO  +: REG_W];
    end
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear)     instr_count <= '0;
    else if (done) instr_count <= instr_count + 1'b1;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (run) state_nxt = S_T0;
      S_T0:   state_nxt = S_T1;
      S_T1:   if (mem_ready) state_nxt = S_T2;
      S_T2:   state_nxt = S_T3;
      S_T3:   state_nxt = (cls == C_ILL) ? (run ? S_T0 : S_IDLE) : S_T4;
      S_T4:   state_nxt = S_T5;
      S_T5:   state_nxt = (cls == C_MD) ? S_T6 : (run ? S_T0 : S_IDLE);
      S_T6:   state_nxt = run ? S_T0 : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Moore decode: everything derives from state and the latched fields.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    memRead  = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zin      = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    alu_op   = '0;
    illegal  = 1'b0;
    step     = 3'd0;
    ro_en    = 1'b0;
    ro_idx   = '0;
    ri_en    = 1'b0;
    ri_idx   = '0;
    case (state)
      S_T0: begin
        PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1;
      end
      S_T1: begin
        step = 3'd1; memRead = 1'b1; MDRin = 1'b1;
      end
      S_T2: begin
        step = 3'd2; MDRout = 1'b1; IRin = 1'b1;
      end
      S_T3: begin
        step = 3'd3;
        if (cls == C_ILL) illegal = 1'b1;
        else begin
          Yin    = 1'b1;
          ro_en  = 1'b1;
          ro_idx = (cls == C_MD) ? ra_q : rb_q;
        end
      end
      S_T4: begin
        step   = 3'd4;
        Zin    = 1'b1;
        alu_op = opc_q;
        ro_en  = 1'b1;
        ro_idx = (cls == C_MD) ? rb_q : rc_q;
      end
      S_T5: begin
        step    = 3'd5;
        Zlowout = 1'b1;
        if (cls == C_MD) LOin = 1'b1;
        else begin
          ri_en  = 1'b1;
          ri_idx = ra_q;
        end
      end
      S_T6: begin
        step = 3'd6; Zhighout = 1'b1; HIin = 1'b1;
      end
      default: ;
    endcase
  end

  reg_select_decoder #(.NREG(NREG), .REG_W(REG_W)) u_rout_dec (
    .idx(ro_idx), .en(ro_en), .onehot(r_out)
  );

  reg_select_decoder #(.NREG(NREG), .REG_W(REG_W)) u_rin_dec (
    .idx(ri_idx), .en(ri_en), .onehot(r_in)
  );

endmodule

// File: tb/tb_alu_control_sequencer.sv
// Self-checking bench for alu_control_sequencer. A reference model expands
// each instruction into the per-cycle sequence of expected outputs; a second
// instance with a 2-bit counter checks counter wrap on the same stimulus.
module tb_alu_control_sequencer;

  typedef struct packed {
    logic pc, mar, inc, mrd, mdri, mdro, iri, yi, zi, zlo, zhi, hii, loi;
    logic [15:0] ro;
    logic [15:0] ri;
    logic [4:0]  op;
    logic        ill;
    logic [2:0]  stp;
  } obs_t;

  typedef struct {
    obs_t        e;
    logic [15:0] cnt;
    bit          mr;
    bit          rn;
    logic [31:0] irv;
  } item_t;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] ir;

  logic PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin, Yin, Zin;
  logic Zlowout, Zhighout, HIin, LOin, illegal;
  logic [15:0] r_out, r_in, instr_count;
  logic [4:0]  alu_op;
  logic [2:0]  step;

  logic b_pc, b_mar, b_inc, b_mrd, b_mdri, b_mdro, b_iri, b_yi, b_zi;
  logic b_zlo, b_zhi, b_hii, b_loi, b_ill;
  logic [15:0] b_ro, b_ri;
  logic [4:0]  b_op;
  logic [2:0]  b_stp;
  logic [1:0]  b_cnt;

  obs_t obs;
  assign obs = {PCout, MARin, IncPC, memRead, MDRin, MDRout, IRin, Yin, Zin,
                Zlowout, Zhighout, HIin, LOin, r_out, r_in, alu_op, illegal, step};

  always #5 clock = ~clock;

  alu_control_sequencer dut (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .memRead(memRead),
    .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .Zin(Zin),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .r_out(r_out), .r_in(r_in), .alu_op(alu_op), .illegal(illegal),
    .step(step), .instr_count(instr_count)
  );

  alu_control_sequencer #(.CNT_W(2)) dut2 (
    .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(b_pc), .MARin(b_mar), .IncPC(b_inc), .memRead(b_mrd),
    .MDRin(b_mdri), .MDRout(b_mdro), .IRin(b_iri), .Yin(b_yi), .Zin(b_zi),
    .Zlowout(b_zlo), .Zhighout(b_zhi), .HIin(b_hii), .LOin(b_loi),
    .r_out(b_ro), .r_in(b_ri), .alu_op(b_op), .illegal(b_ill),
    .step(b_stp), .instr_count(b_cnt)
  );

  item_t       q[$];
  logic [15:0] mcnt;
  int          tests = 0;
  int          fails = 0;
  int          cyc   = 0;

  function automatic bit rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(input logic [2:0] s);
    obs_t o;
    o = '0;
    o.stp = s;
    return o;
  endfunction

  task automatic push(input obs_t e, input bit mr, input bit rn, input logic [31:0] irv);
    item_t it;
    it.e = e; it.cnt = mcnt; it.mr = mr; it.rn = rn; it.irv = irv;
    q.push_back(it);
  endtask

  task automatic push_idle(input bit rn);
    push(blank(3'd0), rbit(), rn, $urandom());
  endtask

  // Expected cycle-by-cycle behaviour of one instruction from T0 onward.
  task automatic add_instr(input logic [31:0] iw, input int waits, input bit run_end);
    logic [4:0]  opc;
    int          ra, rb, rc;
    bit          rr, md;
    logic [15:0] one;
    obs_t        e;
    one = 16'd1;
    opc = iw[31:27];
    ra  = int'(iw[26:23]);
    rb  = int'(iw[22:19]);
    rc  = int'(iw[18:15]);
    rr  = opc inside {5'd3, 5'd4, 5'd10, 5'd11};
    md  = opc inside {5'd15, 5'd16};
    e = blank(3'd0); e.pc = 1; e.mar = 1; e.inc = 1;
    push(e, rbit(), rbit(), $urandom());
    for (int w = 0; w < waits; w++) begin
      e = blank(3'd1); e.mrd = 1; e.mdri = 1;
      push(e, 1'b0, rbit(), $urandom());
    end
    e = blank(3'd1); e.mrd = 1; e.mdri = 1;
    push(e, 1'b1, rbit(), $urandom());
    e = blank(3'd2); e.mdro = 1; e.iri = 1;
    push(e, rbit(), rbit(), iw);
    e = blank(3'd3);
    if (!rr && !md) begin
      e.ill = 1;
      push(e, rbit(), run_end, $urandom());
      return;
    end
    e.yi = 1; e.ro = one << (rr ? rb : ra);
    push(e, rbit(), rbit(), $urandom());
    e = blank(3'd4); e.zi = 1; e.op = opc; e.ro = one << (rr ? rc : rb);
    push(e, rbit(), rbit(), $urandom());
    e = blank(3'd5); e.zlo = 1;
    if (rr) begin
      e.ri = one << ra;
      push(e, rbit(), run_end, $urandom());
      mcnt = mcnt + 16'd1;
      return;
    end
    e.loi = 1;
    push(e, rbit(), rbit(), $urandom());
    e = blank(3'd6); e.zhi = 1; e.hii = 1;
    push(e, rbit(), run_end, $urandom());
    mcnt = mcnt + 16'd1;
  endtask

  task automatic check(input string tag, input obs_t e, input logic [15:0] c);
    tests++;
    assert (obs === e) else begin
      fails++;
      $error("FAIL %s cyc %0d outputs: got %h expected %h", tag, cyc, obs, e);
    end
    tests++;
    assert (instr_count === c) else begin
      fails++;
      $error("FAIL %s cyc %0d instr_count: got %0d expected %0d", tag, cyc, instr_count, c);
    end
    tests++;
    assert (b_cnt === c[1:0]) else begin
      fails++;
      $error("FAIL %s cyc %0d instr_count(CNT_W=2): got %0d expected %0d", tag, cyc, b_cnt, c[1:0]);
    end
  endtask

  // Check each queued cycle at the falling edge, then drive its inputs.
  task automatic play(input string tag);
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      @(negedge clock);
      cyc++;
      check(tag, it.e, it.cnt);
      run = it.rn; mem_ready = it.mr; ir = it.irv;
    end
  endtask

  initial begin
    logic [4:0]  ops[6];
    logic [4:0]  opc;
    logic [31:0] iw;
    bit          active, re;
    int          base;
    ops = '{5'd3, 5'd4, 5'd10, 5'd11, 5'd15, 5'd16};
    mcnt = '0;
    clear = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;
    @(negedge clock);
    check("reset", blank(3'd0), 16'd0);
    clear = 1'b0;

    push_idle(1'b1); add_instr(32'h5091_8000, 0, 1'b0); push_idle(1'b0);
    play("and");
    push_idle(1'b1); add_instr(32'h5091_8000, 3, 1'b0); push_idle(1'b0);
    play("and_wait");
    push_idle(1'b1); add_instr(32'h7890_0000, 1, 1'b0); push_idle(1'b0);
    play("mul");
    push_idle(1'b1); add_instr(32'hF800_0000, 0, 1'b0); push_idle(1'b0);
    play("illegal");

    // Abort during a T1 wait.
    push_idle(1'b1);
    base = q.size();
    add_instr(32'h5091_8000, 5, 1'b0);
    while (q.size() > base + 3) void'(q.pop_back());
    play("pre_clear");
    @(posedge clock);
    #2 clear = 1'b1;
    #1 mcnt = '0;
    check("clear_t1", blank(3'd0), 16'd0);
    @(negedge clock);
    clear = 1'b0; run = 1'b0; mem_ready = 1'b1;
    push_idle(1'b0); push_idle(1'b0);
    play("post_clear");

    push_idle(1'b1);
    for (int k = 0; k < 5; k++) add_instr(32'h5091_8000, 0, k != 4);
    push_idle(1'b0);
    play("b2b");

    active = 1'b0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) == 0) opc = 5'($urandom());
      else opc = ops[$urandom_range(0, 5)];
      iw = {opc, 27'($urandom())};
      if (!active) begin
        for (int k = 0; k < int'($urandom_range(0, 2)); k++) push_idle(1'b0);
        push_idle(1'b1);
      end
      re = rbit();
      add_instr(iw, int'($urandom_range(0, 3)), re);
      active = re;
      play("random");
    end
    if (active) begin
      // Final instruction ended with run high: one more fetch follows.
      add_instr(32'h5091_8000, 0, 1'b0);
    end
    push_idle(1'b0);
    play("tail");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
